lcd_text_driver: RTL and testbench
==================================

# lcd_text_driver

Character-LCD controller that consumes the 32-character status string assembled by the CPU top level and drives an HD44780-compatible panel over its 4-bit interface. It performs the power-up initialisation sequence and then refreshes both 16-character lines continuously. It also honours a clear request from the top level. It sits directly downstream of the top-level string builder and is the only block that touches the LCD pins.

## Interface
- T_PWRUP, 1_000_000: power-up wait in clock cycles (20 ms at 50 MHz).
- T_INIT1, 205_000: wait after first 0x3 init nibble (4.1 ms).
- T_INIT2, 5_000: wait after second and third 0x3 nibbles (100 µs).
- T_CMD, 2_000: wait after any byte except clear (40 µs).
- T_CLEAR, 82_000: wait after clear-display 0x01 (1.64 ms).
- T_NIB, 50: gap between high and low nibble of one byte (1 µs).
- T_E, 12: E high time and E setup time, in cycles.
- CCLK  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- cls  in  1  clear request; any cycle high sets a sticky pending flag.
- strdata  in  256  32 ASCII chars; char i = strdata[255-8i -: 8]; chars 0–15 go to line 1, chars 16–31 go to line 2.
- rs  out  1  LCD register select (0 = command, 1 = data).
- rw  out  1  LCD read/write; tied 0 (write only).
- e  out  1  LCD enable strobe.
- dat  out  4  LCD data nibble DB7..DB4.
- init_done  out  1  high once the initialisation sequence completes.

## Operation
- Reset values: e=0, rs=0, rw=0, dat=0, init_done=0, cls-pending=0; FSM in PWRUP.
- PWRUP: count T_PWRUP cycles, then go to INIT_NIB.
- INIT_NIB: send single nibbles 0x3, 0x3, 0x3, 0x2 (rs=0).
  - Wait T_INIT1 after the first nibble, T_INIT2 after the second and third, T_CMD after 0x2.
- INIT_CMD: send bytes 0x28, 0x06, 0x0C, 0x01.
  - Wait T_CMD after each, except T_CLEAR after 0x01.
  - Then assert init_done and go to FRAME.
- FRAME: snapshot strdata into an internal 256-bit buffer.
  - If cls-pending is set: clear it, send 0x01, wait T_CLEAR.
  - Then go to ADDR1.
- ADDR1: send 0x80 (rs=0), then CHARS1.
- CHARS1: send buffer chars 0–15 (rs=1), then ADDR2.
- ADDR2: send 0xC0, then CHARS2.
- CHARS2: send chars 16–31, then return to FRAME. The loop runs forever.
- Byte transfer: high nibble, T_NIB gap, low nibble, then the post-byte wait.
- Nibble strobe: rs/dat stable T_E cycles, e high T_E cycles, e low, rs/dat held T_E more cycles.
- cls handling:
  - cls asserted during a frame does not interrupt it; the clear occurs at the next FRAME.
  - cls asserted in the same cycle the pending flag is consumed leaves the flag set.
  - cls before init_done is remembered.
- A strdata change mid-frame is invisible until the next snapshot.
- A char counter (5 bits) selects chars and saturates at 31. No wrap-around is exposed.

## Timing
- All outputs are registered. e never glitches.
- First e rise occurs at T_PWRUP + T_E + 1 cycles after rst_n release.
- Minimum byte duration is 2·(3·T_E) + T_NIB + post-wait cycles.
- Frame length without clear is 34 bytes × (6·T_E + T_NIB + T_CMD) plus FRAME overhead of at most 2 cycles.
- rst_n low at any point (including e high): all outputs return to reset values asynchronously. The sequence restarts from PWRUP on release.

## Structure
- Shared package holds:
  - LCD command constants: FUNC_SET_4B2L=0x28, ENTRY_INC=0x06, DISP_ON=0x0C, CLEAR=0x01, DDRAM_L1=0x80, DDRAM_L2=0xC0.
  - The FSM state enum.
- Sub-module lcd_nibble_tx:
  - Inputs: start, rs_in, nib_in.
  - Outputs: rs, dat, e, done.
  - Owns the T_E strobe timing.
  - The parent FSM owns sequencing and the long waits through one shared down-counter.

## Test plan
Use scaled parameters: T_PWRUP=100, T_INIT1=40, T_INIT2=10, T_CMD=8, T_CLEAR=30, T_NIB=3, T_E=2.

- Reset and power-up:
  - Stimulus: hold rst_n low, then release.
  - Required: all outputs 0 during reset; first e rise at cycle 103 after release with dat=0x3, rs=0.
- Initialisation:
  - Stimulus: run from reset release; capture nibbles on e falling edges.
  - Required: stream is 3,3,3,2,2,8,0,6,0,C,0,1; init_done rises after the 30-cycle clear wait.
- Frame content:
  - Stimulus: strdata = "01234567 00 0123f01d01e01m01w01 ".
  - Required: bytes 0x80, 0x30..0x37, 0x20, 0x30, 0x30, 0x20, 0x30..0x33, then 0xC0, 'f','0','1','d',…,0x20; rs=1 exactly on character bytes.
- Clear request:
  - Stimulus: one-cycle cls pulse while char 5 of line 1 is being sent.
  - Required: current frame completes unchanged; next frame starts 0x01 (rs=0), then at least 30 idle cycles, then 0x80.
- Snapshot coherency:
  - Stimulus: change strdata char 20 mid-line-1.
  - Required: the old value is sent this frame and the new value next frame.
- Reset mid-strobe:
  - Stimulus: drop rst_n while e=1.
  - Required: e=0 in the same cycle (asynchronous); after release, the sequence replays from PWRUP and init_done=0.

Source files
------------

// File: rtl/lcd_text_driver_pkg.sv
`default_nettype none
// ==================================================================
// lcd_text_driver_pkg : HD44780 command set, FSM encodings, helpers
// Revision 1.0
// ==================================================================
package lcd_text_driver_pkg;

   localparam logic [7:0] FUNC_SET_4B2L = 8'h28;
   localparam logic [7:0] ENTRY_INC     = 8'h06;
   localparam logic [7:0] DISP_ON       = 8'h0C;
   localparam logic [7:0] CLEAR         = 8'h01;
   localparam logic [7:0] DDRAM_L1      = 8'h80;
   localparam logic [7:0] DDRAM_L2      = 8'hC0;

   typedef enum logic [2:0] {
      ST_PWRUP, ST_INIT_NIB, ST_INIT_CMD, ST_FRAME,
      ST_ADDR1, ST_CHARS1, ST_ADDR2, ST_CHARS2
   } lcd_state_e;

   typedef enum logic [1:0] {PH_WAIT, PH_TX_HI, PH_GAP, PH_TX_LO} xfer_phase_e;

   typedef enum logic [1:0] {TX_IDLE, TX_SETUP, TX_HIGH, TX_HOLD} tx_phase_e;

   function automatic logic [7:0] init_cmd(input logic [1:0] i);
      case (i)
         2'd0:    return FUNC_SET_4B2L;
         2'd1:    return ENTRY_INC;
         2'd2:    return DISP_ON;
         default: return CLEAR;
      endcase
   endfunction

   // Char 0 lives in the top byte; ~idx is 31-idx for a 5-bit index.
   function automatic logic [7:0] char_at(input logic [255:0] s, input logic [4:0] idx);
      return s[{~idx, 3'b000} +: 8];
   endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_text_driver_nibble_tx.sv
`default_nettype none
// ==================================================================
// lcd_nibble_tx : one 4-bit strobe with T_E setup, high and hold
// Revision 1.0
// ==================================================================
module lcd_nibble_tx
   import lcd_text_driver_pkg::*;
#(
   parameter int T_E = 12
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       rs_in,
   input  logic [3:0] nib_in,
   output logic       rs,
   output logic [3:0] dat,
   output logic       e,
   output logic       done
);

   localparam int            CW        = $clog2(T_E) + 1;
   localparam logic [CW-1:0] C_TE_LAST = CW'(T_E - 1);

   tx_phase_e     phase_q;
   logic [CW-1:0] cnt_q;
   logic          rs_q;
   logic          e_q;
   logic [3:0]    dat_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase_q <= TX_IDLE;
         cnt_q   <= '0;
         rs_q    <= 1'b0;
         e_q     <= 1'b0;
         dat_q   <= 4'h0;
      end else begin
         case (phase_q)
            TX_IDLE: if (start) begin
               rs_q    <= rs_in;
               dat_q   <= nib_in;
               cnt_q   <= C_TE_LAST;
               phase_q <= TX_SETUP;
            end
            TX_SETUP: if (cnt_q == '0) begin
               e_q     <= 1'b1;
               cnt_q   <= C_TE_LAST;
               phase_q <= TX_HIGH;
            end else cnt_q <= cnt_q - CW'(1);
            TX_HIGH: if (cnt_q == '0) begin
               e_q     <= 1'b0;
               cnt_q   <= C_TE_LAST;
               phase_q <= TX_HOLD;
            end else cnt_q <= cnt_q - CW'(1);
            TX_HOLD: if (cnt_q == '0) phase_q <= TX_IDLE;
                     else cnt_q <= cnt_q - CW'(1);
            default: phase_q <= TX_IDLE;
         endcase
      end
   end

   assign rs   = rs_q;
   assign dat  = dat_q;
   assign e    = e_q;
   assign done = (phase_q == TX_HOLD) && (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/lcd_text_driver.sv
`default_nettype none
// ==================================================================
// lcd_text_driver : HD44780 4-bit init and continuous 2x16 refresh
// Revision 1.0
// ==================================================================
module lcd_text_driver
   import lcd_text_driver_pkg::*;
#(
   parameter int T_PWRUP = 1_000_000,
   parameter int T_INIT1 = 205_000,
   parameter int T_INIT2 = 5_000,
   parameter int T_CMD   = 2_000,
   parameter int T_CLEAR = 82_000,
   parameter int T_NIB   = 50,
   parameter int T_E     = 12
) (
   input  logic         CCLK,
   input  logic         rst_n,
   input  logic         cls,
   input  logic [255:0] strdata,
   output logic         rs,
   output logic         rw,
   output logic         e,
   output logic [3:0]   dat,
   output logic         init_done
);

   localparam int TMAX_A = (T_PWRUP > T_INIT1) ? T_PWRUP : T_INIT1;
   localparam int TMAX_B = (T_CLEAR > T_INIT2) ? T_CLEAR : T_INIT2;
   localparam int TMAX_C = (T_CMD > T_NIB) ? T_CMD : T_NIB;
   localparam int TMAX_D = (TMAX_A > TMAX_B) ? TMAX_A : TMAX_B;
   localparam int TMAX   = (TMAX_D > TMAX_C) ? TMAX_D : TMAX_C;
   localparam int CW     = $clog2(TMAX + 1);

   // Waits are measured from the end of one strobe to the load of the next;
   // the start and done handshakes eat two cycles of each wait.
   localparam logic [CW-1:0] C_PWRUP = CW'(T_PWRUP - 1);
   localparam logic [CW-1:0] C_INIT1 = CW'(T_INIT1 - 2);
   localparam logic [CW-1:0] C_INIT2 = CW'(T_INIT2 - 2);
   localparam logic [CW-1:0] C_CMD   = CW'(T_CMD - 2);
   localparam logic [CW-1:0] C_CLEAR = CW'(T_CLEAR - 2);
   localparam logic [CW-1:0] C_NIB   = CW'(T_NIB - 2);

   lcd_state_e    state_q;
   xfer_phase_e   phase_q;
   logic [CW-1:0] cnt_q;
   logic [7:0]    byte_q;
   logic          brs_q;
   logic          single_q;
   logic [4:0]    idx_q;
   logic          pend_q;
   logic          init_done_q;
   logic [255:0]  buf_q;
   logic          start_q;
   logic          tx_rs_q;
   logic [3:0]    tx_nib_q;

   logic          w_done;
   logic [CW-1:0] w_post;
   lcd_state_e    w_nstate;
   logic [4:0]    w_nidx;
   logic [7:0]    w_nbyte;
   logic          w_nrs;
   logic          w_nsingle;

   always_comb begin
      w_post = C_CMD;
      if (state_q == ST_INIT_NIB) begin
         case (idx_q)
            5'd0:       w_post = C_INIT1;
            5'd1, 5'd2: w_post = C_INIT2;
            default:    w_post = C_CMD;
         endcase
      end else if (!brs_q && byte_q == CLEAR) begin
         w_post = C_CLEAR;
      end
   end

   // What follows the item currently finishing on the bus.
   always_comb begin
      w_nstate  = state_q;
      w_nidx    = idx_q;
      w_nbyte   = byte_q;
      w_nrs     = 1'b0;
      w_nsingle = 1'b0;
      case (state_q)
         ST_INIT_NIB: if (idx_q == 5'd3) begin
            w_nstate = ST_INIT_CMD;
            w_nidx   = 5'd0;
            w_nbyte  = FUNC_SET_4B2L;
         end else begin
            w_nidx    = idx_q + 5'd1;
            w_nbyte   = (idx_q == 5'd2) ? 8'h20 : 8'h30;
            w_nsingle = 1'b1;
         end
         ST_INIT_CMD: if (idx_q == 5'd3) w_nstate = ST_FRAME;
         else begin
            w_nidx  = idx_q + 5'd1;
            w_nbyte = init_cmd(idx_q[1:0] + 2'd1);
         end
         ST_FRAME: begin
            w_nstate = ST_ADDR1;
            w_nbyte  = DDRAM_L1;
         end
         ST_ADDR1: begin
            w_nstate = ST_CHARS1;
            w_nidx   = 5'd0;
            w_nbyte  = char_at(buf_q, 5'd0);
            w_nrs    = 1'b1;
         end
         ST_CHARS1: if (idx_q == 5'd15) begin
            w_nstate = ST_ADDR2;
            w_nbyte  = DDRAM_L2;
         end else begin
            w_nidx  = idx_q + 5'd1;
            w_nbyte = char_at(buf_q, idx_q + 5'd1);
            w_nrs   = 1'b1;
         end
         ST_ADDR2: begin
            w_nstate = ST_CHARS2;
            w_nidx   = 5'd16;
            w_nbyte  = char_at(buf_q, 5'd16);
            w_nrs    = 1'b1;
         end
         ST_CHARS2: if (idx_q == 5'd31) w_nstate = ST_FRAME;
         else begin
            w_nidx  = idx_q + 5'd1;
            w_nbyte = char_at(buf_q, idx_q + 5'd1);
            w_nrs   = 1'b1;
         end
         default: w_nstate = state_q;
      endcase
   end

   always_ff @(posedge CCLK or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_PWRUP;
         phase_q     <= PH_WAIT;
         cnt_q       <= C_PWRUP;
         byte_q      <= 8'h30;
         brs_q       <= 1'b0;
         single_q    <= 1'b1;
         idx_q       <= 5'd0;
         pend_q      <= 1'b0;
         init_done_q <= 1'b0;
         buf_q       <= '0;
         start_q     <= 1'b0;
         tx_rs_q     <= 1'b0;
         tx_nib_q    <= 4'h0;
      end else begin
         start_q <= 1'b0;
         pend_q  <= pend_q | cls;
         case (phase_q)
            PH_WAIT: if (cnt_q != '0) cnt_q <= cnt_q - CW'(1);
            else begin
               start_q  <= 1'b1;
               tx_rs_q  <= brs_q;
               tx_nib_q <= byte_q[7:4];
               phase_q  <= PH_TX_HI;
               case (state_q)
                  ST_PWRUP: state_q <= ST_INIT_NIB;
                  ST_FRAME: begin
                     init_done_q <= 1'b1;
                     buf_q       <= strdata;
                     tx_rs_q     <= 1'b0;
                     brs_q       <= 1'b0;
                     single_q    <= 1'b0;
                     if (pend_q) begin
                        pend_q   <= cls;
                        byte_q   <= CLEAR;
                        tx_nib_q <= CLEAR[7:4];
                     end else begin
                        state_q  <= ST_ADDR1;
                        byte_q   <= DDRAM_L1;
                        tx_nib_q <= DDRAM_L1[7:4];
                     end
                  end
                  default: state_q <= state_q;
               endcase
            end
            PH_TX_HI: if (w_done) begin
               if (single_q) begin
                  state_q  <= w_nstate;
                  idx_q    <= w_nidx;
                  byte_q   <= w_nbyte;
                  brs_q    <= w_nrs;
                  single_q <= w_nsingle;
                  cnt_q    <= w_post;
                  phase_q  <= PH_WAIT;
               end else begin
                  cnt_q   <= C_NIB;
                  phase_q <= PH_GAP;
               end
            end
            PH_GAP: if (cnt_q != '0) cnt_q <= cnt_q - CW'(1);
            else begin
               start_q  <= 1'b1;
               tx_nib_q <= byte_q[3:0];
               phase_q  <= PH_TX_LO;
            end
            PH_TX_LO: if (w_done) begin
               state_q  <= w_nstate;
               idx_q    <= w_nidx;
               byte_q   <= w_nbyte;
               brs_q    <= w_nrs;
               single_q <= w_nsingle;
               cnt_q    <= w_post;
               phase_q  <= PH_WAIT;
            end
            default: phase_q <= PH_WAIT;
         endcase
      end
   end

   lcd_nibble_tx #(.T_E(T_E)) u_tx (
      .clk    (CCLK),
      .rst_n  (rst_n),
      .start  (start_q),
      .rs_in  (tx_rs_q),
      .nib_in (tx_nib_q),
      .rs     (rs),
      .dat    (dat),
      .e      (e),
      .done   (w_done)
   );

   assign rw        = 1'b0;
   assign init_done = init_done_q;

endmodule
`default_nettype wire

// File: tb/tb_lcd_text_driver.sv
`default_nettype none
// ==================================================================
// tb_lcd_text_driver : directed checks of init, refresh, clear, reset
// Revision 1.0
// ==================================================================
module tb_lcd_text_driver;

   logic         CCLK = 1'b0;
   logic         rst_n = 1'b0;
   logic         cls = 1'b0;
   logic [255:0] strdata;
   logic         rs, rw, e, init_done;
   logic [3:0]   dat;

   always #5 CCLK = ~CCLK;

   lcd_text_driver #(
      .T_PWRUP(100), .T_INIT1(40), .T_INIT2(10), .T_CMD(8),
      .T_CLEAR(30), .T_NIB(3), .T_E(2)
   ) dut (
      .CCLK(CCLK), .rst_n(rst_n), .cls(cls), .strdata(strdata),
      .rs(rs), .rw(rw), .e(e), .dat(dat), .init_done(init_done)
   );

   int         cyc;
   logic [3:0] nib    [0:255];
   logic       nrs    [0:255];
   int         fall_c [0:255];
   int         rise_c [0:255];
   int         n_cnt, first_rise, idone_c;
   logic [3:0] first_dat;
   logic       first_rs, e_prev, id_prev;
   int         n_chk = 0;
   int         n_fail = 0;

   always @(posedge CCLK) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   always @(negedge CCLK) begin
      if (!rst_n) begin
         n_cnt = 0; first_rise = -1; idone_c = -1; e_prev = 1'b0; id_prev = 1'b0;
      end else begin
         if (e && !e_prev && n_cnt < 256) begin
            rise_c[n_cnt] = cyc;
            if (first_rise < 0) begin
               first_rise = cyc; first_dat = dat; first_rs = rs;
            end
         end
         if (!e && e_prev && n_cnt < 256) begin
            nib[n_cnt] = dat; nrs[n_cnt] = rs; fall_c[n_cnt] = cyc;
            n_cnt++;
         end
         if (init_done && !id_prev && idone_c < 0) idone_c = cyc;
         e_prev  = e;
         id_prev = init_done;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_nibs(input int n);
      int w = 0;
      while (n_cnt < n && w < 4000) begin
         @(negedge CCLK);
         w++;
      end
      chk($sformatf("wait_nibs_%0d", n), 32'(n_cnt >= n), 32'd1);
   endtask

   function automatic logic [9:0] fexp(input logic [255:0] s, input int b);
      int c;
      if (b == 0)  return {2'b00, 8'h80};
      if (b == 17) return {2'b00, 8'hC0};
      c = (b <= 16) ? b - 1 : b - 2;
      return {2'b11, s[255-8*c -: 8]};
   endfunction

   task automatic check_frame(input int base, input logic [255:0] s, input string tag);
      for (int b = 0; b < 34; b++) begin
         chk($sformatf("%s_byte%0d", tag, b),
             32'({nrs[base+2*b], nrs[base+2*b+1], nib[base+2*b], nib[base+2*b+1]}),
             32'(fexp(s, b)));
      end
   endtask

   logic [255:0] s_old, s_new;
   logic [3:0]   init_exp [12];

   initial begin
      s_old   = "01234567 00 0123f01d01e01m01w01 ";
      strdata = s_old;
      init_exp = '{4'h3, 4'h3, 4'h3, 4'h2, 4'h2, 4'h8, 4'h0, 4'h6, 4'h0, 4'hC, 4'h0, 4'h1};

      repeat (5) @(negedge CCLK);
      #1;
      chk("reset_e", 32'(e), 32'd0);
      chk("reset_rs", 32'(rs), 32'd0);
      chk("reset_rw", 32'(rw), 32'd0);
      chk("reset_dat", 32'(dat), 32'd0);
      chk("reset_init_done", 32'(init_done), 32'd0);

      @(negedge CCLK);
      rst_n = 1'b1;
      wait_nibs(1);
      chk("first_rise_cycle", 32'(first_rise), 32'd103);
      chk("first_rise_dat", 32'(first_dat), 32'h3);
      chk("first_rise_rs", 32'(first_rs), 32'd0);

      wait_nibs(12);
      for (int i = 0; i < 12; i++)
         chk($sformatf("init_nib%0d", i), 32'({nrs[i], nib[i]}), 32'({1'b0, init_exp[i]}));
      chk("init1_spacing", 32'(fall_c[1] - fall_c[0]), 32'd46);
      chk("byte_period", 32'(fall_c[6] - fall_c[4]), 32'd23);

      wait_nibs(14);
      chk("init_done_high", 32'(init_done), 32'd1);
      chk("init_done_after_clear_wait", 32'(idone_c - fall_c[11] >= 30), 32'd1);
      chk("rw_low", 32'(rw), 32'd0);

      wait_nibs(80);
      check_frame(12, s_old, "frame1");

      // Clear request and char 20 change while line-1 char 5 is in flight.
      wait_nibs(93);
      @(negedge CCLK);
      cls = 1'b1;
      s_new = s_old;
      s_new[255-8*20 -: 8] = 8'h5A;
      strdata = s_new;
      @(negedge CCLK);
      cls = 1'b0;

      wait_nibs(148);
      check_frame(80, s_old, "frame2");

      wait_nibs(151);
      chk("clear_byte", 32'({nrs[148], nrs[149], nib[148], nib[149]}), 32'({2'b00, 8'h01}));
      chk("clear_idle_gap", 32'(rise_c[150] - fall_c[149] >= 30), 32'd1);

      wait_nibs(218);
      check_frame(150, s_new, "frame3");

      wait_nibs(220);
      chk("frame4_no_clear", 32'({nrs[218], nrs[219], nib[218], nib[219]}), 32'({2'b00, 8'h80}));

      begin
         int w = 0;
         while (!e && w < 200) begin
            @(negedge CCLK);
            w++;
         end
      end
      chk("e_high_before_reset", 32'(e), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_reset_e", 32'(e), 32'd0);
      chk("async_reset_rs", 32'(rs), 32'd0);
      chk("async_reset_dat", 32'(dat), 32'd0);
      chk("async_reset_init_done", 32'(init_done), 32'd0);

      repeat (3) @(negedge CCLK);
      rst_n = 1'b1;
      wait_nibs(1);
      chk("rerun_first_rise_cycle", 32'(first_rise), 32'd103);
      chk("rerun_first_dat", 32'(first_dat), 32'h3);
      chk("rerun_first_rs", 32'(first_rs), 32'd0);
      chk("rerun_init_done", 32'(init_done), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
